// File: rtl/sha2_eddsa_pkg.sv
// sha2_eddsa_pkg: shared types and constants for the EdDSA SHA-2 message sequencer
package sha2_eddsa_pkg;
   typedef enum logic [3:0] {
      S_IDLE, S_CLR, S_LEN_HI, S_LEN_LO, S_LEN_CPY, S_FILL, S_KICK, S_WAIT, S_ADV
   } state_t;
   localparam int PC_CLR      = 0;
   localparam int PC_LOAD     = 1;
   localparam int PC_START    = 2;
   localparam int PC_LOAD_LEN = 3;
   function automatic int block_bits(input int mode);
      return (mode == 384 || mode == 512) ? 1024 : 512;
   endfunction
   function automatic int len_hi_idx(input int wpb);
      return wpb - 2;
   endfunction
   function automatic int len_lo_idx(input int wpb);
      return wpb - 1;
   endfunction
   function automatic logic [3:0] pc(input int b);
      return 4'(1 << b);
   endfunction
endpackage

// File: rtl/sha2_blk_calc.sv
// sha2_blk_calc: block count and message word count for a bit length, captured on en
module sha2_blk_calc #(
   parameter int WIDTH = 32,
   parameter int BLOCK = 512
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               en,
   input  logic [2*WIDTH-1:0] len,
   output logic [2*WIDTH-1:0] nblk,
   output logic [2*WIDTH-1:0] nwords
);
   localparam int LW  = 2 * WIDTH;
   localparam int LB  = $clog2(BLOCK);
   localparam int LWD = $clog2(WIDTH);
   logic [LW-1:0] sum;
   assign sum = len + LW'(LW);
   always_ff @(posedge clk) begin
      if (!reset) begin
         nblk   <= '0;
         nwords <= '0;
      end else if (en) begin
         nblk   <= (sum >> LB) + LW'(1);
         nwords <= (len >> LWD) + LW'(|len[LWD-1:0]);
      end
   end
endmodule

// File: rtl/sha2_pad_ctrl_eddsa.sv
// sha2_pad_ctrl_eddsa: drives the SHA-2 padding unit and fills/starts the hash core per block
module sha2_pad_ctrl_eddsa
   import sha2_eddsa_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int MODE  = 256,
   localparam int BLOCK = block_bits(MODE),
   localparam int WPB   = BLOCK / WIDTH,
   localparam int AW    = $clog2(WPB)
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               go,
   input  logic [2*WIDTH-1:0] msg_len,
   input  logic               in_valid,
   input  logic [WIDTH-1:0]   in_data,
   output logic               in_ready,
   output logic [3:0]         pad_control,
   output logic [4:0]         pad_ad,
   output logic [WIDTH-1:0]   pad_din,
   input  logic [WIDTH-1:0]   pad_dout,
   output logic               core_we,
   output logic [AW-1:0]      core_addr,
   output logic [WIDTH-1:0]   core_wdata,
   output logic               core_start,
   input  logic               core_done,
   output logic               busy,
   output logic               done
);
   localparam int LW = 2 * WIDTH;
   state_t        state;
   logic [LW-1:0] len, cnt, b, nblk, nwords;
   logic [AW-1:0] w;
   logic [1:0]    a;
   logic          fill, lo, need;

   sha2_blk_calc #(.WIDTH(WIDTH), .BLOCK(BLOCK)) u_calc (
      .clk(clk), .reset(reset), .en(state == S_CLR), .len(len), .nblk(nblk), .nwords(nwords)
   );

   assign fill       = state == S_FILL;
   assign lo         = state == S_LEN_LO || state == S_LEN_CPY;
   assign need       = cnt < nwords;
   assign busy       = state != S_IDLE;
   assign in_ready   = fill && need && in_valid;
   assign core_we    = fill && (need ? in_valid : 1'b1);
   assign core_addr  = fill ? w : '0;
   assign core_wdata = pad_dout;
   assign pad_ad     = fill ? 5'(w) : lo ? 5'd1 : 5'd0;
   assign pad_din    = state == S_LEN_HI ? len[LW-1:WIDTH] : lo ? len[WIDTH-1:0] :
                       (fill && need) ? in_data : '0;

   always_ff @(posedge clk) begin
      if (!reset) begin
         state       <= S_IDLE;
         len         <= '0;
         cnt         <= '0;
         b           <= '0;
         w           <= '0;
         a           <= '0;
         pad_control <= '0;
         core_start  <= 1'b0;
         done        <= 1'b0;
      end else begin
         pad_control <= '0;
         core_start  <= 1'b0;
         done        <= 1'b0;
         case (state)
            S_IDLE: if (go) begin
               len         <= msg_len;
               b           <= '0;
               state       <= S_CLR;
               pad_control <= pc(PC_CLR);
            end
            S_CLR: begin
               state       <= S_LEN_HI;
               pad_control <= pc(PC_LOAD_LEN);
            end
            S_LEN_HI: begin
               state       <= S_LEN_LO;
               pad_control <= pc(PC_LOAD_LEN);
            end
            S_LEN_LO: begin
               state       <= S_LEN_CPY;
               pad_control <= pc(PC_LOAD_LEN);
            end
            S_LEN_CPY: begin
               state <= S_FILL;
               w     <= '0;
               cnt   <= '0;
            end
            S_FILL: if (core_we) begin
               w <= w + AW'(1);
               if (need) cnt <= cnt + LW'(1);
               if (w == AW'(WPB - 1)) begin
                  state      <= S_KICK;
                  core_start <= 1'b1;
               end
            end
            S_KICK: state <= S_WAIT;
            S_WAIT: if (core_done) begin
               b           <= b + LW'(1);
               a           <= '0;
               state       <= S_ADV;
               pad_control <= pc(PC_START);
            end
            S_ADV: begin
               a           <= a + 2'd1;
               pad_control <= (a == 2'd0) ? pc(PC_START) : (a == 2'd1) ? pc(PC_LOAD) : 4'd0;
               if (a == 2'd2) begin
                  if (b < nblk) begin
                     state <= S_FILL;
                     w     <= '0;
                  end else begin
                     state <= S_IDLE;
                     done  <= 1'b1;
                  end
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_sha2_pad_ctrl_eddsa.sv
// tb_sha2_pad_ctrl_eddsa: directed bench with padding-unit and hash-core models
module tb_sha2_pad_ctrl_eddsa;
   logic        clk = 1'b0, reset = 1'b0, go = 1'b0, in_valid = 1'b0, spur_done = 1'b0;
   logic [63:0] msg_len = '0;
   logic [31:0] in_data = '0;
   logic        in_ready, core_we, core_start, core_done, busy, done;
   logic [3:0]  pad_control, core_addr;
   logic [4:0]  pad_ad;
   logic [31:0] pad_din, pad_dout, core_wdata;

   int nchk = 0, nfail = 0;
   int nst = 0, nacc = 0, nwe = 0, ndone = 0, viol = 0, lat = 0;
   int st0 = 0, a0 = 0, we0 = 0, v0 = 0, exp_nw = 0, cyc = 0;
   logic [31:0] mem [256];
   logic [31:0] acc [256];

   sha2_pad_ctrl_eddsa #(.WIDTH(32), .MODE(256)) dut (
      .clk(clk), .reset(reset), .go(go), .msg_len(msg_len), .in_valid(in_valid),
      .in_data(in_data), .in_ready(in_ready), .pad_control(pad_control), .pad_ad(pad_ad),
      .pad_din(pad_din), .pad_dout(pad_dout), .core_we(core_we), .core_addr(core_addr),
      .core_wdata(core_wdata), .core_start(core_start), .core_done(core_done),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // Padding unit model: length register, block counter, and padded word per bit position
   logic [63:0] pl = '0, pp, mnb;
   int          pblk = 0;
   logic        pst = 1'b0;
   always @(posedge clk) begin
      pst <= pad_control[2];
      if (pad_control[0]) begin
         pl   <= '0;
         pblk <= 0;
      end else begin
         if (pad_control[3]) pl <= (pad_ad == 5'd0) ? {pad_din, pl[31:0]} : {pl[63:32], pad_din};
         if (pad_control[2] && !pst) pblk <= pblk + 1;
      end
   end
   always_comb begin
      pp  = 64'(pblk * 16 + int'(pad_ad)) * 64'd32;
      mnb = ((pl + 64'd64) >> 9) + 64'd1;
      if (pp + 64'd32 <= pl) pad_dout = pad_din;
      else if (pp < pl) pad_dout = (pad_din & ~(32'hFFFFFFFF >> (pl - pp))) | (32'h80000000 >> (pl - pp));
      else if (pp == pl) pad_dout = 32'h80000000;
      else if (64'(pblk) == mnb - 64'd1 && pad_ad == 5'd14) pad_dout = pl[63:32];
      else if (64'(pblk) == mnb - 64'd1 && pad_ad == 5'd15) pad_dout = pl[31:0];
      else pad_dout = '0;
   end

   // Core model (3-cycle compress) and output monitor, sampled mid-cycle
   assign core_done = (lat == 1) | spur_done;
   always @(negedge clk) begin
      if (core_we) mem[(nst * 16 + int'(core_addr)) % 256] <= core_wdata;
      nwe <= nwe + int'(core_we);
      if (in_ready) begin
         acc[nacc % 256] <= in_data;
         nacc <= nacc + 1;
      end
      if ((core_we && !in_valid && nacc - a0 < exp_nw) || (in_ready && nacc - a0 >= exp_nw))
         viol <= viol + 1;
      if (core_start) begin
         nst <= nst + 1;
         lat <= 4;
      end else if (lat != 0) lat <= lat - 1;
      if (done) ndone <= ndone + 1;
   end

   function automatic logic [31:0] dat(input int i);
      return 32'((i + 1) * 32'h11111111);
   endfunction

   function automatic logic [31:0] m(input int blk, input int wi);
      return mem[((st0 + blk) * 16 + wi) % 256];
   endfunction

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      nchk++;
      assert (got === exp) else begin
         nfail++;
         $error("FAIL %s observed=%h expected=%h", tag, got, exp);
      end
   endtask

   task automatic run(input logic [63:0] l, input int nw, input bit tog, input bit g2);
      int  d0, c;
      bit  sent;
      st0 = nst; a0 = nacc; we0 = nwe; v0 = viol; d0 = ndone; exp_nw = nw;
      sent = 1'b0; c = 0;
      msg_len = l; go = 1'b1;
      @(posedge clk); #1;
      go = 1'b0;
      while (ndone == d0 && c < 400) begin
         in_valid = tog ? ~in_valid : 1'b1;
         in_data = dat(nacc - a0);
         go = 1'b0;
         if (g2 && !sent && nst != st0) begin
            go = 1'b1;
            msg_len = 64'd1024;
            sent = 1'b1;
         end
         spur_done = (c == 10);
         @(posedge clk); #1;
         c++;
      end
      in_valid = 1'b0; go = 1'b0; spur_done = 1'b0; cyc = c;
      chk("timeout", 64'(c < 400), 64'd1);
      repeat (3) @(posedge clk);
      #1;
      chk("done_once", 64'(ndone - d0), 64'd1);
      chk("idle_after", 64'(busy), 64'd0);
   endtask

   initial begin
      int c;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_outs", 64'({in_ready, core_we, core_start, done, pad_control, pad_ad, pad_din}), 64'd0);
      reset = 1'b1;
      @(posedge clk); #1;

      // L=0: single block, padding bit at word 0
      run(64'd0, 0, 1'b0, 1'b0);
      chk("t1_latency", 64'(cyc), 64'd28);
      chk("t1_accepted", 64'(nacc - a0), 64'd0);
      chk("t1_writes", 64'(nwe - we0), 64'd16);
      chk("t1_starts", 64'(nst - st0), 64'd1);
      chk("t1_w0", 64'(m(0, 0)), 64'h80000000);
      chk("t1_w13", 64'(m(0, 13)), 64'h0);
      chk("t1_w14", 64'(m(0, 14)), 64'h0);
      chk("t1_w15", 64'(m(0, 15)), 64'h0);

      // L=256: eight words then padding and length in one block
      run(64'd256, 8, 1'b0, 1'b0);
      chk("t2_latency", 64'(cyc), 64'd28);
      chk("t2_accepted", 64'(nacc - a0), 64'd8);
      chk("t2_starts", 64'(nst - st0), 64'd1);
      chk("t2_acc3", 64'(acc[(a0 + 3) % 256]), 64'h44444444);
      chk("t2_w0", 64'(m(0, 0)), 64'h11111111);
      chk("t2_w7", 64'(m(0, 7)), 64'h88888888);
      chk("t2_w8", 64'(m(0, 8)), 64'h80000000);
      chk("t2_w14", 64'(m(0, 14)), 64'h0);
      chk("t2_w15", 64'(m(0, 15)), 64'h00000100);

      // L=448: length spills into a second block
      run(64'd448, 14, 1'b0, 1'b0);
      chk("t3_starts", 64'(nst - st0), 64'd2);
      chk("t3_accepted", 64'(nacc - a0), 64'd14);
      chk("t3_b0w13", 64'(m(0, 13)), 64'hEEEEEEEE);
      chk("t3_b0w14", 64'(m(0, 14)), 64'h80000000);
      chk("t3_b0w15", 64'(m(0, 15)), 64'h0);
      chk("t3_b1w0", 64'(m(1, 0)), 64'h0);
      chk("t3_b1w14", 64'(m(1, 14)), 64'h0);
      chk("t3_b1w15", 64'(m(1, 15)), 64'h000001C0);

      // L=1024 with in_valid toggling: stalls and three blocks
      run(64'd1024, 32, 1'b1, 1'b0);
      chk("t4_starts", 64'(nst - st0), 64'd3);
      chk("t4_accepted", 64'(nacc - a0), 64'd32);
      chk("t4_writes", 64'(nwe - we0), 64'd48);
      chk("t4_stall_viol", 64'(viol - v0), 64'd0);
      chk("t4_acc31", 64'(acc[(a0 + 31) % 256]), 64'(dat(31)));
      chk("t4_b0w1", 64'(m(0, 1)), 64'(dat(1)));
      chk("t4_b1w15", 64'(m(1, 15)), 64'(dat(31)));
      chk("t4_b2w0", 64'(m(2, 0)), 64'h80000000);
      chk("t4_b2w14", 64'(m(2, 14)), 64'h0);
      chk("t4_b2w15", 64'(m(2, 15)), 64'h00000400);

      // Reset during FILL word 5, then a clean L=256 run
      st0 = nst; a0 = nacc; exp_nw = 8;
      msg_len = 64'd256; go = 1'b1;
      @(posedge clk); #1;
      go = 1'b0; c = 0;
      while (nacc - a0 < 5 && c < 100) begin
         in_valid = 1'b1;
         in_data = dat(nacc - a0);
         @(posedge clk); #1;
         c++;
      end
      chk("t5_reach", 64'(c < 100), 64'd1);
      reset = 1'b0;
      @(posedge clk); #1;
      chk("t5_busy", 64'(busy), 64'd0);
      chk("t5_outs", 64'({in_ready, core_we, core_start, done, pad_control, pad_ad, core_addr}), 64'd0);
      chk("t5_din", 64'(pad_din), 64'd0);
      chk("t5_nostart", 64'(nst - st0), 64'd0);
      reset = 1'b1; in_valid = 1'b0;
      @(posedge clk); #1;
      run(64'd256, 8, 1'b0, 1'b0);
      chk("t5_starts", 64'(nst - st0), 64'd1);
      chk("t5_w4", 64'(m(0, 4)), 64'h55555555);
      chk("t5_w8", 64'(m(0, 8)), 64'h80000000);
      chk("t5_w15", 64'(m(0, 15)), 64'h00000100);

      // go re-pulsed during WAIT with a different length is ignored
      run(64'd256, 8, 1'b0, 1'b1);
      chk("t6_starts", 64'(nst - st0), 64'd1);
      chk("t6_accepted", 64'(nacc - a0), 64'd8);
      chk("t6_w15", 64'(m(0, 15)), 64'h00000100);

      $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
      $finish;
   end
endmodule
